// File: rtl/imem_line_refill_pkg.sv
// Shared defaults and the refill FSM state type for the instruction-memory line refill path.
package imem_line_refill_pkg;
  localparam int IMEM_WORD          = 32;
  localparam int IMEM_LINE_WORDS    = 4;
  localparam int IMEM_RAM_DEPTH_LOG = 10;
  localparam int IMEM_RD_LAT        = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } refill_state_t;
endpackage

// File: rtl/imem_line_refill_rd_pipe.sv
// Delay line matching BRAM read latency: the issue strobe emerges as recv RD_LAT cycles later.
module imem_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic recv
);
  logic [RD_LAT-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | RD_LAT'(issue);
  end

  assign recv = sr[RD_LAT-1];
endmodule

// File: rtl/imem_line_refill.sv
// Serves one ICache line refill: LINE_WORDS back-to-back BRAM reads, assembles the line, pulses memory_ready.
module imem_line_refill
  import imem_line_refill_pkg::*;
#(
  parameter int WORD          = IMEM_WORD,
  parameter int LINE_WORDS    = IMEM_LINE_WORDS,
  parameter int RAM_DEPTH_LOG = IMEM_RAM_DEPTH_LOG,
  parameter int RD_LAT        = IMEM_RD_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       memory_valid,
  input  logic [WORD-1:0]            load_addr,
  output logic                       memory_ready,
  output logic [WORD*LINE_WORDS-1:0] inst_from_mem,
  output logic                       mem_en,
  output logic [RAM_DEPTH_LOG-1:0]   mem_addr,
  input  logic [WORD-1:0]            mem_dout,
  output logic                       busy
);
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int CNT_W  = IDX_W + 1;
  localparam int LINE_W = WORD * LINE_WORDS;

  refill_state_t state, state_nxt;
  logic [CNT_W-1:0]         issue_cnt, recv_cnt;
  logic [RAM_DEPTH_LOG-1:0] base, addr_q, issue_addr;
  logic [LINE_W-1:0]        line_buf, line_nxt;
  logic                     recv, accept, line_done;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{load_addr[WORD-1:RAM_DEPTH_LOG+2], load_addr[1:0]};

  imem_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .issue (mem_en),
    .recv  (recv)
  );

  assign accept     = (state == S_IDLE) && memory_valid;
  assign issue_addr = base + RAM_DEPTH_LOG'(issue_cnt);
  // Look ahead to the final word so DONE follows its capture edge directly.
  assign line_done  = (recv_cnt == CNT_W'(LINE_WORDS)) ||
                      (recv && (recv_cnt == CNT_W'(LINE_WORDS - 1)));

  assign mem_en       = (state == S_ISSUE);
  assign mem_addr     = mem_en ? issue_addr : addr_q;
  assign memory_ready = (state == S_DONE);
  assign busy         = (state != S_IDLE);

  always_comb begin
    line_nxt = line_buf;
    if (recv) line_nxt[WORD*int'(recv_cnt[IDX_W-1:0]) +: WORD] = mem_dout;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (memory_valid) state_nxt = S_ISSUE;
      S_ISSUE: if (issue_cnt == CNT_W'(LINE_WORDS - 1)) state_nxt = S_DRAIN;
      S_DRAIN: if (line_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      base          <= '0;
      addr_q        <= '0;
      line_buf      <= '0;
      inst_from_mem <= '0;
    end else begin
      state    <= state_nxt;
      line_buf <= line_nxt;
      if (state == S_DRAIN && line_done) inst_from_mem <= line_nxt;
      if (accept) begin
        base      <= load_addr[RAM_DEPTH_LOG+1:2] & ~RAM_DEPTH_LOG'(LINE_WORDS - 1);
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (mem_en) begin
          addr_q <= issue_addr;
          if (issue_cnt != CNT_W'(LINE_WORDS)) issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (recv) recv_cnt <= recv_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_imem_line_refill.sv
// Two instances (RD_LAT 1 and 2) with BRAM models, checked against a line/latency reference model.
module tb_imem_line_refill;
  localparam int LW    = 4;
  localparam int DEPTH = 1024;
  localparam int LAT [2] = '{1, 2};

  logic         clk = 1'b0;
  logic         rst;
  logic         mv   [2];
  logic [31:0]  la   [2];
  logic         rdy  [2];
  logic [127:0] ln   [2];
  logic         me   [2];
  logic [9:0]   ma   [2];
  logic [31:0]  dout [2];
  logic         bsy  [2];
  logic [31:0]  ram  [DEPTH];
  logic [31:0]  s0, s1a, s1b;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_line_refill #(.RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .memory_valid(mv[0]), .load_addr(la[0]), .memory_ready(rdy[0]),
    .inst_from_mem(ln[0]), .mem_en(me[0]), .mem_addr(ma[0]), .mem_dout(dout[0]), .busy(bsy[0]));
  imem_line_refill #(.RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .memory_valid(mv[1]), .load_addr(la[1]), .memory_ready(rdy[1]),
    .inst_from_mem(ln[1]), .mem_en(me[1]), .mem_addr(ma[1]), .mem_dout(dout[1]), .busy(bsy[1]));

  always @(posedge clk) if (me[0]) s0 <= ram[ma[0]];
  always @(posedge clk) begin
    if (me[1]) s1a <= ram[ma[1]];
    s1b <= s1a;
  end
  assign dout[0] = s0;
  assign dout[1] = s1b;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic refill(input int k, input logic [31:0] addr, input int drop_c, output int ready_cyc);
    logic [127:0] exp;
    int base, n_iss, ready_c;
    base = int'(((addr >> 2) % DEPTH) & ~(LW - 1));
    for (int i = 0; i < LW; i++) exp[32*i +: 32] = ram[(base + i) % DEPTH];
    mv[k] = 1'b1;
    la[k] = addr;
    n_iss = 0;
    ready_c = -1;
    ready_cyc = -1;
    for (int c = 1; c <= 30 && ready_c < 0; c++) begin
      @(negedge clk);
      if (c == drop_c) mv[k] = 1'b0;
      if (c == 1) check("busy_on", bsy[k], 1);
      if (me[k]) begin
        check("issue_addr", ma[k], (base + n_iss) % DEPTH);
        check("issue_cycle", c, n_iss + 1);
        n_iss++;
      end
      if (rdy[k]) begin
        ready_c = c;
        ready_cyc = cyc;
      end
    end
    check("ready_latency", ready_c, LW + LAT[k] + 1);
    check("words_issued", n_iss, LW);
    check("line", ln[k], exp);
    check("en_after_issue", me[k], 0);
    check("addr_hold", ma[k], (base + LW - 1) % DEPTH);
    mv[k] = 1'b0;
    la[k] = $urandom;
    @(negedge clk);
    check("ready_pulse", rdy[k], 0);
    check("busy_idle", bsy[k], 0);
    check("line_hold", ln[k], exp);
  endtask

  initial begin
    int r1, r2, seen;
    for (int i = 0; i < DEPTH; i++) ram[i] = (i < 64) ? 32'h1000 + i : $urandom;
    rst = 1'b1;
    mv = '{1'b0, 1'b0};
    la = '{32'h0, 32'h0};
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", rdy[k], 0);
      check("rst_line", ln[k], 0);
      check("rst_en", me[k], 0);
      check("rst_addr", ma[k], 0);
      check("rst_busy", bsy[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    refill(0, 32'h14, 0, r1);
    check("known_line", ln[0], {32'h1007, 32'h1006, 32'h1005, 32'h1004});

    refill(0, 32'h0, 0, r1);
    refill(0, 32'h10, 0, r2);
    check("b2b_spacing", r2 - r1, 7);

    refill(1, 32'h3C, 0, r1);
    check("lat2_line", ln[1], {32'h100F, 32'h100E, 32'h100D, 32'h100C});

    refill(0, 32'h100, 2, r1);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      seen += int'(bsy[0]);
    end
    check("no_second_req", seen, 0);

    refill(0, 4 * (DEPTH - 4), 0, r1);
    refill(1, 4 * (DEPTH - 4), 0, r1);

    // Abort a refill three cycles in.
    mv[0] = 1'b1;
    la[0] = 32'h40;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", rdy[0], 0);
    check("abort_line", ln[0], 0);
    check("abort_en", me[0], 0);
    check("abort_addr", ma[0], 0);
    check("abort_busy", bsy[0], 0);
    mv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen += int'(rdy[0]) + int'(bsy[0]);
    end
    check("abort_quiet", seen, 0);
    refill(0, 32'h40, 0, r1);

    for (int n = 0; n < 24; n++) begin
      int k;
      k = n % 2;
      refill(k, $urandom, $urandom_range(0, LW), r1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_line_refill.md
# imem_line_refill

Memory-side responder for the instruction cache refill port. It accepts one cache-line request from `ICache` (`memory_valid`, `load_addr`), performs `LINE_WORDS` sequential word reads from a synchronous single-port instruction BRAM, and assembles the words into one line. It returns the line on `inst_from_mem` with a one-cycle `memory_ready` pulse. It sits between `ICache` and the instruction memory inside `CPU_top`.

## Interface
Parameters:
- `WORD`, 32: word width in bits (from `` `WORD ``).
- `LINE_WORDS`, 4: words per cache line; power of two, at least 2; `` `CACHE_LINE_WIDTH `` = `WORD*LINE_WORDS`.
- `RAM_DEPTH_LOG`, 10: log2 of BRAM depth in words.
- `RD_LAT`, 1: BRAM read latency in cycles, 1 or 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `memory_valid` in 1: refill request from `ICache`; held high with `load_addr` stable until `memory_ready`.
- `load_addr` in `WORD`: byte address of the missing instruction.
- `memory_ready` out 1: one-cycle pulse; `inst_from_mem` is valid in that cycle.
- `inst_from_mem` out `WORD*LINE_WORDS`: assembled line; word i is at bits `[WORD*i +: WORD]`.
- `mem_en` out 1: BRAM read enable.
- `mem_addr` out `RAM_DEPTH_LOG`: BRAM word index.
- `mem_dout` in `WORD`: BRAM read data, valid `RD_LAT` cycles after the `mem_en` cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - When `memory_valid`=1, latch `base` = `load_addr[RAM_DEPTH_LOG+1:2]` with the low log2(`LINE_WORDS`) bits cleared.
  - Clear `issue_cnt` and `recv_cnt`, then go to ISSUE.
- ISSUE:
  - Each cycle: `mem_en`=1, `mem_addr` = `base + issue_cnt`, then increment `issue_cnt`.
  - The add is modulo 2^`RAM_DEPTH_LOG`. Alignment means it never carries out of the line, so there is no wrap across the line.
  - After word `LINE_WORDS-1` is issued, go to DRAIN.
- Read return tracking:
  - A delay line of depth `RD_LAT` carries the issue strobe.
  - When it emerges, `mem_dout` is written into line slot `recv_cnt`, then `recv_cnt` increments.
  - Slot writes can occur during ISSUE as well as DRAIN.
- DRAIN: wait until `recv_cnt` == `LINE_WORDS`, then go to DONE.
- DONE:
  - `memory_ready`=1 for exactly one cycle, with `inst_from_mem` = the completed line; then go to IDLE.
  - `memory_valid` is ignored in DONE. `ICache` drops it after seeing ready.
- Outside DONE, `inst_from_mem` holds its last value. Only `memory_ready` qualifies it.
- Requests are never cancelled. Once accepted, a refill completes even if `memory_valid` falls or `ICache` is flushed.
- Counters are log2(`LINE_WORDS`)+1 bits wide; `issue_cnt` saturates at `LINE_WORDS`.
- `mem_en`=0 and `mem_addr` holds its value in every state other than ISSUE.

## Timing
- Reset values: `memory_ready`=0, `inst_from_mem`=0, `mem_en`=0, `mem_addr`=0, `busy`=0, state IDLE, delay line cleared.
- Latency (request sampled at edge T):
  - ISSUE spans cycles T+1 through T+`LINE_WORDS`.
  - The last word is captured at the end of cycle T+`LINE_WORDS`+`RD_LAT`.
  - `memory_ready` is high in cycle T+`LINE_WORDS`+`RD_LAT`+1.
  - With defaults, this is 6 cycles after the request edge.
- Earliest next acceptance: the IDLE cycle after DONE. Back-to-back refills take `LINE_WORDS`+`RD_LAT`+2 cycles each.
- Throughput during ISSUE: one BRAM read per cycle, with no bubbles.
- Reset asserted mid-refill: all state clears immediately. A data word returning after reset is discarded, because the delay line is cleared. No `memory_ready` is issued for the aborted request.
- `memory_valid` high in the same cycle reset deasserts: the request is sampled at the first clock edge after deassertion.

## Structure
- `` `WORD ``, `` `CACHE_LINE_WIDTH `` and `` `RAM_DEPTH_LOG `` come from `CPU_Parameter.vh`.
- Add an `` `IMEM_RD_LAT `` macro there. Local state encodings stay inside the module.
- One sub-module: `imem_rd_pipe`, a parameterised `RD_LAT`-deep shift register of the issue strobe with asynchronous clear. It produces the `recv` strobe.

## Test plan
- Single refill, `load_addr`=0x0000_0014 with BRAM[i]=0x1000+i, `RD_LAT`=1:
  - `mem_addr` issues 4, 5, 6, 7 on consecutive cycles.
  - `memory_ready` pulses 6 cycles after the request edge.
  - `inst_from_mem` = {0x1007, 0x1006, 0x1005, 0x1004}.
- Back-to-back: `load_addr` 0x0 is followed at the first IDLE cycle by 0x10. Both lines are returned correctly, 7 cycles apart, and `busy` drops for exactly 1 cycle between them.
- `RD_LAT`=2, `load_addr`=0x3C: the line holds words 12–15, and `memory_ready` appears at T+7.
- `memory_valid` is dropped during ISSUE: the refill still completes, and no second request starts.
- Reset is asserted 3 cycles into a refill: all outputs return to their reset values immediately. No `memory_ready` appears, and a fresh request after reset returns correct data.
- Top of memory, `load_addr` = 4*(2^`RAM_DEPTH_LOG`-4): `mem_addr` issues depth-4 through depth-1, with no wrap into index 0.
